// File: rtl/tmds_decoder_rx_pkg.sv
// Shared constants and types for the TMDS receive decoder.
// Control symbols, lock FSM encoding, counter width.
package tmds_decoder_rx_pkg;

  localparam int CNT_W = 26;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // For control symbols d[1:0] carries {c1, c0}.
  typedef struct packed {
    logic       is_data;
    logic [7:0] d;
  } sym_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_decoder_rx_if.sv
// TMDS symbol inputs and decoded video outputs.
// slave: decoder side, master: source/monitor side.
interface tmds_decoder_rx_if;
  import tmds_decoder_rx_pkg::*;

  logic [9:0]       tmds_b;
  logic [9:0]       tmds_g;
  logic [9:0]       tmds_r;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] cntX;
  logic [CNT_W-1:0] cntY;
  logic             sym_err;
  logic             locked;

  modport slave (
    input  tmds_b, tmds_g, tmds_r,
    output red, green, blue, de,
    output hsync, vsync, cntX, cntY,
    output sym_err, locked
  );

  modport master (
    output tmds_b, tmds_g, tmds_r,
    input  red, green, blue, de,
    input  hsync, vsync, cntX, cntY,
    input  sym_err, locked
  );

endinterface

// File: rtl/tmds_symbol_decoder.sv
// One TMDS channel: classify control/data and decode,
// registered once.
module tmds_symbol_decoder
  import tmds_decoder_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] q,
  output sym_t       sym
);

  sym_t       nxt;
  logic [7:0] qi;

  always_comb begin
    nxt = '0;
    qi  = q[9] ? ~q[7:0] : q[7:0];
    unique case (1'b1)
      (q == CTRL_00): nxt.d = 8'd0;
      (q == CTRL_01): nxt.d = 8'd1;
      (q == CTRL_10): nxt.d = 8'd2;
      (q == CTRL_11): nxt.d = 8'd3;
      default: begin
        nxt.is_data = 1'b1;
        nxt.d[0]    = qi[0];
        for (int i = 1; i < 8; i++)
          nxt.d[i] = q[8] ? (qi[i] ^ qi[i-1])
                          : ~(qi[i] ^ qi[i-1]);
      end
    endcase
  end

  // Reset value reads as a c=00 control symbol.
  always_ff @(posedge clk) begin
    if (rst) sym <= '0;
    else     sym <= nxt;
  end

endmodule

// File: rtl/tmds_decoder_rx.sv
// TMDS/DVI receive decoder: 3 channel decode, sync
// extraction, pixel/line counters and timing lock.
module tmds_decoder_rx
  import tmds_decoder_rx_pkg::*;
#(
  parameter int h_pixel     = 800,
  parameter int v_pixel     = 600,
  parameter int lock_frames = 2
) (
  input logic              pixclk,
  input logic              rst,
  tmds_decoder_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(h_pixel - 1);
  localparam logic [CNT_W-1:0] V_LINES =
    CNT_W'(v_pixel);
  localparam logic [7:0] LOCK_N = 8'(lock_frames);

  sym_t sb, sg, sr;

  tmds_symbol_decoder u_b (
    .clk(pixclk), .rst(rst),
    .q(bus.tmds_b), .sym(sb)
  );
  tmds_symbol_decoder u_g (
    .clk(pixclk), .rst(rst),
    .q(bus.tmds_g), .sym(sg)
  );
  tmds_symbol_decoder u_r (
    .clk(pixclk), .rst(rst),
    .q(bus.tmds_r), .sym(sr)
  );

  lock_state_t      state;
  logic [7:0]       good_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             frame_bad;

  logic all_data, mix, hs_n, vs_n;
  logic rise_v, fall_de, bad_line;
  logic line_done, frame_fail;

  // Events are taken between current and next output.
  always_comb begin
    all_data = sb.is_data & sg.is_data & sr.is_data;
    mix      = ~all_data &
               (sb.is_data | sg.is_data | sr.is_data);
    hs_n     = bus.hsync;
    vs_n     = bus.vsync;
    if (!all_data && !sb.is_data) begin
      hs_n = sb.d[0];
      vs_n = sb.d[1];
    end
    rise_v     = vs_n & ~bus.vsync;
    fall_de    = bus.de & ~all_data;
    bad_line   = fall_de &
                 (rise_v | (bus.cntX != H_LAST));
    line_done  = fall_de & ~rise_v;
    frame_fail = frame_bad | bad_line | mix |
                 (line_cnt != V_LINES);
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      bus.red     <= '0;
      bus.green   <= '0;
      bus.blue    <= '0;
      bus.de      <= 1'b0;
      bus.hsync   <= 1'b0;
      bus.vsync   <= 1'b0;
      bus.sym_err <= 1'b0;
      bus.cntX    <= '0;
      bus.cntY    <= '0;
    end else begin
      bus.red     <= all_data ? sr.d : '0;
      bus.green   <= all_data ? sg.d : '0;
      bus.blue    <= all_data ? sb.d : '0;
      bus.de      <= all_data;
      bus.hsync   <= hs_n;
      bus.vsync   <= vs_n;
      bus.sym_err <= mix;
      bus.cntX    <= (all_data && bus.de)
                     ? sat_inc(bus.cntX) : '0;
      if (rise_v)       bus.cntY <= '0;
      else if (fall_de) bus.cntY <= sat_inc(bus.cntY);
    end
  end

  // locked trails state by one cycle.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      line_cnt   <= '0;
      frame_bad  <= 1'b0;
      bus.locked <= 1'b0;
    end else begin
      bus.locked <= (state == LOCKED);
      if (line_done)      line_cnt  <= sat_inc(line_cnt);
      if (bad_line | mix) frame_bad <= 1'b1;
      unique case (state)
        SEARCH: if (rise_v) begin
          state     <= CHECK;
          good_cnt  <= '0;
          line_cnt  <= '0;
          frame_bad <= 1'b0;
        end
        CHECK: if (rise_v) begin
          line_cnt  <= '0;
          frame_bad <= 1'b0;
          if (frame_fail) begin
            state <= SEARCH;
          end else begin
            good_cnt <= good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_N)
              state <= LOCKED;
          end
        end
        LOCKED: begin
          if (bad_line || mix) begin
            state <= SEARCH;
          end else if (rise_v) begin
            line_cnt  <= '0;
            frame_bad <= 1'b0;
            if (line_cnt != V_LINES) state <= SEARCH;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder_rx.sv
// Directed bench for tmds_decoder_rx with a DVI encoder
// for stimulus; reduced 16x6 (24x10 total) frame timing.
module tb_tmds_decoder_rx;
  import tmds_decoder_rx_pkg::*;

  localparam int HP = 16;
  localparam int VP = 6;
  localparam int HT = 24;
  localparam int VT = 10;
  localparam logic [9:0] W00 = 10'b0100000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmds_decoder_rx_if bus ();

  tmds_decoder_rx #(
    .h_pixel(HP),
    .v_pixel(VP),
    .lock_frames(2)
  ) dut (
    .pixclk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   db = 0, dg = 0, dr = 0;
  int   max_x = 0, max_y = 0, falls = 0;
  logic prev_de = 1'b0;
  logic lk_fall = 1'b0, lk_next = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cw(input logic [1:0] c);
    logic [9:0] w;
    unique case (c)
      2'd0: w = CTRL_00;
      2'd1: w = CTRL_01;
      2'd2: w = CTRL_10;
      2'd3: w = CTRL_11;
    endcase
    return w;
  endfunction

  task automatic enc(input logic [7:0] d,
                     inout int cnt,
                     output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1, n0;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++)
        qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++)
        qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      q = {~qm[8], qm[8],
           qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt = qm[8] ? cnt + n1 - n0 : cnt + n0 - n1;
    end else if ((cnt > 0 && n1 > n0) ||
                 (cnt < 0 && n0 > n1)) begin
      q   = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      q   = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - 2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  // One pixclk: apply words, sample #1 after the edge.
  task automatic drive(input logic [9:0] b, g, r);
    bus.tmds_b = b;
    bus.tmds_g = g;
    bus.tmds_r = r;
    @(posedge clk);
    #1;
    if (bus.de === 1'b1) begin
      if (int'(bus.cntX) > max_x) max_x = int'(bus.cntX);
      if (int'(bus.cntY) > max_y) max_y = int'(bus.cntY);
    end
    if (falls == 1) begin
      lk_next = bus.locked;
      falls   = 2;
    end else if (falls == 0 && prev_de &&
                 bus.de === 1'b0) begin
      lk_fall = bus.locked;
      falls   = 1;
    end
    prev_de = (bus.de === 1'b1);
  endtask

  task automatic pix(input logic [7:0] b, g, r);
    logic [9:0] qb, qg, qr;
    enc(b, db, qb);
    enc(g, dg, qg);
    enc(r, dr, qr);
    drive(qb, qg, qr);
  endtask

  task automatic ctl(input logic [1:0] c);
    db = 0;
    dg = 0;
    dr = 0;
    drive(cw(c), CTRL_00, CTRL_00);
  endtask

  task automatic frame(input int short_row);
    int len;
    max_x = 0;
    max_y = 0;
    falls = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        len = (v == short_row) ? HP - 1 : HP;
        if (v < VP && h < len)
          pix(8'(255 - h), 8'(h * 7 + v), 8'(h + 16 * v));
        else
          ctl({v >= 7 && v < 9, h >= 18 && h < 21});
      end
    end
  endtask

  logic [7:0] vals [4];
  logic [9:0] qb, qr;

  initial begin
    vals = '{8'h00, 8'hFF, 8'h55, 8'hA5};
    bus.tmds_b = CTRL_00;
    bus.tmds_g = CTRL_00;
    bus.tmds_r = CTRL_00;

    ctl(2'd0);
    ctl(2'd0);
    chk("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
    chk("rst_flags", {bus.de, bus.hsync, bus.vsync,
                      bus.sym_err, bus.locked}, 0);
    chk("rst_cntx", bus.cntX, 0);
    chk("rst_cnty", bus.cntY, 0);
    rst = 1'b0;
    ctl(2'd0);
    ctl(2'd0);

    drive(W00, W00, W00);
    ctl(2'd0);
    chk("w00_de", bus.de, 1);
    chk("w00_rgb", {bus.red, bus.green, bus.blue}, 0);
    ctl(2'd0);
    for (int i = 0; i < 4; i++) begin
      pix(vals[i], vals[i], vals[i]);
      chk("lat_guard", bus.de, 0);
      ctl(2'd0);
      chk("data_de", bus.de, 1);
      chk("data_rgb", {bus.red, bus.green, bus.blue},
          {vals[i], vals[i], vals[i]});
    end

    drive(CTRL_01, CTRL_00, CTRL_00);
    ctl(2'd0);
    chk("c01_sync", {bus.de, bus.hsync, bus.vsync}, 3'b010);
    chk("c01_rgb", {bus.red, bus.green, bus.blue}, 0);
    drive(CTRL_11, CTRL_00, CTRL_00);
    drive(CTRL_11, CTRL_00, CTRL_00);
    chk("c11_sync", {bus.de, bus.hsync, bus.vsync}, 3'b011);
    pix(8'h11, 8'h22, 8'h33);
    drive(CTRL_11, CTRL_00, CTRL_00);
    chk("hold_sync", {bus.de, bus.hsync, bus.vsync}, 3'b111);
    chk("hold_rgb", {bus.red, bus.green, bus.blue},
        24'h332211);
    ctl(2'd0);
    ctl(2'd0);
    chk("c00_sync", {bus.hsync, bus.vsync}, 0);

    rst = 1'b1;
    ctl(2'd0);
    rst = 1'b0;
    frame(-1);
    frame(-1);
    chk("lock_f2", bus.locked, 0);
    frame(-1);
    chk("lock_f3", bus.locked, 1);
    chk("max_cntx", max_x, HP - 1);
    chk("max_cnty", max_y, VP - 1);
    chk("cnty_end", bus.cntY, 0);

    frame(0);
    chk("short_fall", lk_fall, 1);
    chk("short_next", lk_next, 0);
    chk("short_end", bus.locked, 0);
    frame(-1);
    chk("relock_f1", bus.locked, 0);
    frame(-1);
    chk("relock_f2", bus.locked, 1);

    ctl(2'd0);
    chk("pre_mix", bus.locked, 1);
    enc(8'h3C, db, qb);
    enc(8'hC3, dr, qr);
    drive(qb, CTRL_00, qr);
    ctl(2'd0);
    chk("mix_err", {bus.sym_err, bus.de}, 2'b10);
    chk("mix_rgb", {bus.red, bus.green, bus.blue}, 0);
    ctl(2'd0);
    chk("mix_pulse", bus.sym_err, 0);
    chk("mix_unlock", bus.locked, 0);

    pix(8'h01, 8'h02, 8'h03);
    pix(8'h04, 8'h05, 8'h06);
    chk("pre_rst_x0", {bus.de, 26'(bus.cntX)}, 27'h4000000);
    pix(8'h07, 8'h08, 8'h09);
    chk("pre_rst_x1", bus.cntX, 1);
    rst = 1'b1;
    pix(8'h0A, 8'h0B, 8'h0C);
    rst = 1'b0;
    chk("mid_rgb", {bus.red, bus.green, bus.blue}, 0);
    chk("mid_flags", {bus.de, bus.hsync, bus.vsync,
                      bus.sym_err, bus.locked}, 0);
    chk("mid_cntx", bus.cntX, 0);
    chk("mid_cnty", bus.cntY, 0);
    pix(8'h0D, 8'h0E, 8'h0F);
    chk("post_de0", bus.de, 0);
    pix(8'h10, 8'h11, 8'h12);
    chk("post_x0", {bus.de, 26'(bus.cntX)}, 27'h4000000);
    pix(8'h13, 8'h14, 8'h15);
    chk("post_x1", bus.cntX, 1);
    ctl(2'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_decoder_rx.md
TMDS_DECODER_RX -- requirements
Module: tmds_decoder_rx

Interface
REQ-001 Parameter h_pixel, default 800: active pixels per line.
REQ-002 Parameter v_pixel, default 600: active lines per frame.
REQ-003 Parameter lock_frames, default 2: consecutive good frames required for lock.
REQ-004 pixclk  in  1: pixel clock; the only clock, all logic on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 tmds_b  in  10: word-aligned blue-channel TMDS symbol, bit 0 first on wire.
REQ-007 tmds_g  in  10: word-aligned green-channel TMDS symbol.
REQ-008 tmds_r  in  10: word-aligned red-channel TMDS symbol.
REQ-009 red, green, blue  out  8 each: decoded pixel data.
REQ-010 de  out  1: data enable; high for video-data symbols.
REQ-011 hsync, vsync  out  1 each: blue-channel control bits c0, c1.
REQ-012 cntX  out  26: active pixel index within line.
REQ-013 cntY  out  26: active line index within frame.
REQ-014 sym_err  out  1: one-cycle pulse when any channel carries an invalid symbol.
REQ-015 locked  out  1: timing matches h_pixel x v_pixel.

Function
REQ-016 Each channel SHALL classify its word as control when it equals 1101010100 (c=00), 0010101011 (c=01), 0101010100 (c=10) or 1010101011 (c=11), else as data.
REQ-017 Data decode SHALL be: if q[9]=1, invert q[7:0]; then d[0]=q[0]; d[i]=q[i]^q[i-1] if q[8]=1, else ~(q[i]^q[i-1]), for i=1..7.
REQ-018 de SHALL be high only when all three channels are data; a mix of control and data SHALL assert sym_err and force de=0.
REQ-019 When de=0, hsync and vsync SHALL take c0 and c1 from blue, and red/green/blue SHALL be 0; when de=1, hsync and vsync SHALL hold their last control values.
REQ-020 Latency from an input word to red/green/blue, de, hsync, vsync and sym_err SHALL be exactly 2 pixclk cycles; cntX and cntY SHALL align with the same output cycle.
REQ-021 cntX SHALL be 0 on the first de=1 cycle of a line, increment each de=1 cycle, and reset to 0 when de falls; it SHALL saturate at 2^26-1.
REQ-022 cntY SHALL increment on each de falling edge and reset to 0 on the vsync rising edge; it SHALL saturate at 2^26-1.
REQ-023 The lock FSM SHALL have states SEARCH, CHECK and LOCKED; locked=1 only in LOCKED.
REQ-024 SEARCH -> CHECK on a vsync rising edge; the good-frame count SHALL be cleared.
REQ-025 In CHECK and LOCKED, a line is bad if it has a de run length != h_pixel; a frame is bad if it has a bad line, if its completed-line count at the next vsync rise != v_pixel, or if sym_err occurred.
REQ-026 CHECK: a bad frame -> SEARCH; a good frame increments the count, and reaching lock_frames -> LOCKED.
REQ-027 LOCKED: a bad line or sym_err -> SEARCH immediately; a frame-count mismatch at the vsync rise -> SEARCH.
REQ-028 A vsync rise while de=1 (truncated line) SHALL count as a bad line.

Reset
REQ-029 While rst=1: all outputs 0, FSM in SEARCH, counters and pipeline registers 0.
REQ-030 Reset mid-frame SHALL discard partial counts; lock SHALL require a new vsync rise followed by lock_frames good frames.

Structure
REQ-031 A shared package SHALL hold the four control-symbol constants, the FSM state encoding and the 26-bit counter width.
REQ-032 One sub-module, tmds_symbol_decoder (one channel: classify + decode, 1-cycle registered), SHALL be instantiated three times.

Verification
REQ-033 Encoded byte 0x00 (word 0100000000 → verify via reference encoder), 0xFF, 0x55 and 0xA5 on all channels -> identical bytes on red/green/blue after 2 cycles.
REQ-034 Blue 0010101011, other channels 1101010100 -> de=0, hsync=1, vsync=0; blue 1010101011 -> hsync=1, vsync=1.
REQ-035 Three 800x600 frames (1056x628 total, sync from encoder) -> locked=1 after the 3rd vsync rise; cntX reaches 799 and cntY reaches 599.
REQ-036 A 799-pixel line injected while locked -> locked=0 on the cycle after de falls, and relock after 2 further good frames.
REQ-037 Green carries a control symbol while red and blue carry data -> sym_err pulse of 1 cycle, de=0, and the FSM returns to SEARCH.
REQ-038 rst asserted mid-line for 1 cycle -> all outputs 0 the next cycle; cntX restarts at 0 on the next de rise.
